// File: rtl/frame_move_ctrl.sv
// Frame-paced mover: queues one-hot key directions in a small FIFO and,
// on each frame pulse, pops one and steps the object with wrap-around.
// Ports: vga_clk, sys_rst_n (sync, active-low), frame, key_flag[3:0]
//   in; pos_x/pos_y[9:0], dir[1:0], upd, cmd_cnt[2:0], ovf out.
module frame_move_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int STEP       = 10,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       frame,
  input  logic [3:0] key_flag,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       upd,
  output logic [2:0] cmd_cnt,
  output logic       ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] FULL = 3'(FIFO_DEPTH);
  localparam logic [9:0] HA   = 10'(H_ACTIVE);
  localparam logic [9:0] VA   = 10'(V_ACTIVE);
  localparam logic [9:0] ST   = 10'(STEP);
  localparam logic [9:0] XI   = 10'(X_INIT);
  localparam logic [9:0] YI   = 10'(Y_INIT);

  localparam logic [1:0] D_UP = 2'd0;
  localparam logic [1:0] D_DN = 2'd1;
  localparam logic [1:0] D_LT = 2'd2;
  localparam logic [1:0] D_RT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MOVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    dnext_q, dnext_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          upd_q, upd_d;

  logic       key_one;
  logic [1:0] key_enc;
  logic       pop;
  logic       push;
  logic       drop;

  always_comb begin
    key_one = $onehot(key_flag);
    key_enc = D_UP;
    if (key_one) begin
      unique case (1'b1)
        key_flag[0]: key_enc = D_UP;
        key_flag[1]: key_enc = D_DN;
        key_flag[2]: key_enc = D_LT;
        key_flag[3]: key_enc = D_RT;
        default:     key_enc = D_UP;
      endcase
    end
  end

  // A pop in the same cycle frees a slot for a push into a full FIFO.
  // An empty FIFO cannot pop, so a coincident key waits a frame.
  always_comb begin
    pop  = (state_q == IDLE) && frame && (cnt_q != 3'd0);
    push = key_one && ((cnt_q != FULL) || pop);
    drop = key_one && (cnt_q == FULL) && !pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dnext_d = dnext_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    upd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame) begin
          dnext_d = pop ? mem_q[rd_ptr_q] : dir_q;
          state_d = LOAD;
        end
      end
      LOAD: begin
        dir_d   = dnext_q;
        state_d = MOVE;
      end
      MOVE: begin
        upd_d   = 1'b1;
        state_d = IDLE;
        unique case (dir_q)
          D_UP: y_d = (y_q < ST) ? y_q + VA - ST : y_q - ST;
          D_DN: y_d = (y_q + ST >= VA) ? y_q + ST - VA : y_q + ST;
          D_LT: x_d = (x_q < ST) ? x_q + HA - ST : x_q - ST;
          D_RT: x_d = (x_q + ST >= HA) ? x_q + ST - HA : x_q + ST;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= 3'd0;
      ovf_q    <= 1'b0;
      dir_q    <= D_RT;
      dnext_q  <= D_RT;
      x_q      <= XI;
      y_q      <= YI;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      dir_q    <= dir_d;
      dnext_q  <= dnext_d;
      x_q      <= x_d;
      y_q      <= y_d;
      upd_q    <= upd_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge vga_clk) begin
    if (sys_rst_n && push) mem_q[wr_ptr_q] <= key_enc;
  end

  assign pos_x   = x_q;
  assign pos_y   = y_q;
  assign dir     = dir_q;
  assign upd     = upd_q;
  assign cmd_cnt = cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_frame_move_ctrl.sv
// Directed self-checking bench for frame_move_ctrl.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_frame_move_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame;
  logic [3:0] key;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [1:0] dir;
  logic       upd;
  logic [2:0] cmd_cnt;
  logic       ovf;

  int n_chk;
  int n_fail;

  frame_move_ctrl dut (
    .vga_clk  (clk),
    .sys_rst_n(rst_n),
    .frame    (frame),
    .key_flag (key),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .dir      (dir),
    .upd      (upd),
    .cmd_cnt  (cmd_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame = 1'b0;
    key   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_key(input logic [3:0] k);
    key = k;
    tick();
    key = 4'b0000;
  endtask

  // Frame pulse (optionally with a coincident key), then checks dir
  // one edge later and the upd pulse window.
  task automatic do_frame(input logic [3:0] k, input int edir,
                          input string tag);
    frame = 1'b1;
    key   = k;
    tick();
    frame = 1'b0;
    key   = 4'b0000;
    tick();
    check({tag, "_dir"}, int'(dir), edir);
    check({tag, "_upd_early"}, int'(upd), 0);
    tick();
    check({tag, "_upd"}, int'(upd), 1);
    tick();
    check({tag, "_upd_off"}, int'(upd), 0);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    frame  = 1'b0;
    key    = 4'b0000;

    do_reset();
    check("rst_x", int'(pos_x), 320);
    check("rst_y", int'(pos_y), 240);
    check("rst_dir", int'(dir), 3);
    check("rst_upd", int'(upd), 0);
    check("rst_cnt", int'(cmd_cnt), 0);
    check("rst_ovf", int'(ovf), 0);

    // Idle frame keeps heading right.
    do_frame(4'b0000, 3, "f0");
    check("f0_x", int'(pos_x), 330);
    check("f0_y", int'(pos_y), 240);

    // Single up key.
    do_reset();
    push_key(4'b0001);
    check("up_cnt1", int'(cmd_cnt), 1);
    do_frame(4'b0000, 0, "up");
    check("up_cnt0", int'(cmd_cnt), 0);
    check("up_y", int'(pos_y), 230);
    check("up_x", int'(pos_x), 320);

    // Right-edge wrap and left wrap back.
    do_reset();
    run_frames(31);
    check("wr_x630", int'(pos_x), 630);
    run_frames(1);
    check("wr_x0", int'(pos_x), 0);
    push_key(4'b0100);
    do_frame(4'b0000, 2, "wl");
    check("wl_x", int'(pos_x), 630);
    check("wl_y", int'(pos_y), 240);

    // Overflow and FIFO order.
    do_reset();
    push_key(4'b0001);
    push_key(4'b0100);
    push_key(4'b0010);
    push_key(4'b1000);
    check("of_ovf0", int'(ovf), 0);
    push_key(4'b0001);
    check("of_cnt", int'(cmd_cnt), 4);
    check("of_ovf", int'(ovf), 1);
    do_frame(4'b0000, 0, "q0");
    do_frame(4'b0000, 2, "q1");
    do_frame(4'b0000, 1, "q2");
    do_frame(4'b0000, 3, "q3");
    check("q_cnt", int'(cmd_cnt), 0);
    check("q_ovf", int'(ovf), 1);
    // Net: up10, left10, down10, right10 -> back to start.
    check("q_x", int'(pos_x), 320);
    check("q_y", int'(pos_y), 240);

    // Invalid keys are ignored.
    push_key(4'b0011);
    push_key(4'b0000);
    push_key(4'b1111);
    check("inv_cnt", int'(cmd_cnt), 0);
    check("inv_ovf", int'(ovf), 1);

    // Key with frame on empty FIFO: applied next frame.
    do_frame(4'b0100, 3, "ce0");
    check("ce_cnt", int'(cmd_cnt), 1);
    do_frame(4'b0000, 2, "ce1");
    check("ce_cnt0", int'(cmd_cnt), 0);

    // Key with frame on full FIFO: accepted, no overflow.
    do_reset();
    push_key(4'b0001);
    push_key(4'b0100);
    push_key(4'b0010);
    push_key(4'b1000);
    check("cf_cnt4", int'(cmd_cnt), 4);
    frame = 1'b1;
    key   = 4'b0010;
    tick();
    frame = 1'b0;
    key   = 4'b0000;
    check("cf_cnt", int'(cmd_cnt), 4);
    check("cf_ovf", int'(ovf), 0);
    tick();
    check("cf_dir", int'(dir), 0);
    tick();
    tick();
    do_frame(4'b0000, 2, "cf1");
    do_frame(4'b0000, 1, "cf2");
    do_frame(4'b0000, 3, "cf3");
    do_frame(4'b0000, 1, "cf4");
    check("cf_end", int'(cmd_cnt), 0);

    // Reset while in MOVE: no update completes.
    do_reset();
    for (int i = 0; i < 5; i++) push_key(4'b0001);
    check("rm_ovf1", int'(ovf), 1);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    check("rm_dir0", int'(dir), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rm_upd", int'(upd), 0);
    check("rm_x", int'(pos_x), 320);
    check("rm_y", int'(pos_y), 240);
    check("rm_dir", int'(dir), 3);
    check("rm_cnt", int'(cmd_cnt), 0);
    check("rm_ovf", int'(ovf), 0);
    tick();
    check("rm_upd2", int'(upd), 0);
    check("rm_y2", int'(pos_y), 240);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_move_ctrl.md
Name: frame_move_ctrl

Overview:
- Consumer of the per-frame `frame` pulse and the debounced `key_flag` events in the VGA game path.
- Queues direction commands from keys in a small FIFO.
- On each frame pulse, pops one command (if any) and steps an object coordinate by STEP pixels, wrapping inside the active area.
- Outputs feed the pixel-drawing logic as the object's current position and heading.

Parameters:
- H_ACTIVE, 640, horizontal active pixels; x range is 0..H_ACTIVE-1.
- V_ACTIVE, 480, vertical active lines; y range is 0..V_ACTIVE-1.
- STEP, 10, pixels moved per frame; must satisfy 0 < STEP < min(H_ACTIVE, V_ACTIVE).
- X_INIT, 320, reset x.
- Y_INIT, 240, reset y.
- FIFO_DEPTH, 4, command queue depth; power of two.

Ports:
- vga_clk  input  1  working clock, 25 MHz.
- sys_rst_n  input  1  reset, synchronous, active-low.
- frame  input  1  one-cycle pulse, one per frame.
- key_flag  input  4  one-cycle key pulses: [0] up, [1] down, [2] left, [3] right.
- pos_x  output  10  object x.
- pos_y  output  10  object y.
- dir  output  2  current heading: 0 up, 1 down, 2 left, 3 right.
- upd  output  1  one-cycle pulse when pos/dir have just been updated.
- cmd_cnt  output  3  FIFO occupancy, 0..FIFO_DEPTH.
- ovf  output  1  sticky: a key was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is synchronous and active-low on sys_rst_n, sampled on the rising edge of vga_clk.
- Reset values: pos_x=X_INIT, pos_y=Y_INIT, dir=3, upd=0, cmd_cnt=0, ovf=0, FIFO pointers=0, state=IDLE.
- Reset asserted mid-operation (any state): all of the above take effect at that edge. No pending update completes.
- Key push rules:
  - Push happens only if key_flag has exactly one bit set; the encoded direction is written.
  - 0 or more than one bit set: no push, no flag.
  - FIFO full on push: the entry is dropped and ovf is set to 1. ovf is cleared only by reset.
- State machine IDLE -> LOAD -> MOVE -> IDLE:
  - IDLE: on frame=1, if cmd_cnt>0, pop the head into a dir_next register; else dir_next=dir. Go to LOAD.
  - LOAD: dir <= dir_next. Go to MOVE.
  - MOVE: update one coordinate per dir using wrap arithmetic, assert upd=1 for this one cycle, go to IDLE.
- Latency: frame sampled at edge N -> dir valid after edge N+1 -> pos and upd valid after edge N+2.
- frame=1 while in LOAD or MOVE: ignored, no queuing.
- Simultaneous push and pop in the IDLE frame cycle:
  - Both take effect; cmd_cnt is unchanged.
  - If the FIFO was empty before that cycle, the new key is not popped this frame; it stays for the next frame.
  - If the FIFO was full before that cycle, the pop frees a slot, the push is accepted, and ovf is not set.
- Wrap arithmetic (unsigned, 10-bit, no intermediate overflow because values stay below 1024):
  - right: x+STEP >= H_ACTIVE ? x+STEP-H_ACTIVE : x+STEP
  - left: x < STEP ? x+H_ACTIVE-STEP : x-STEP
  - down/up: same forms on y with V_ACTIVE.
  - The non-moving coordinate holds.
- The FIFO is circular: pointers wrap modulo FIFO_DEPTH. Entries pop in push order.
- Reversal (e.g. right then left) is allowed; no filtering in this block.

Test Plan:
- Reset released, no keys, one frame pulse -> dir=3 after 1 cycle; pos_x=330, pos_y=240 and upd=1 for exactly one cycle, 2 cycles after frame.
- key_flag=4'b0001 for one cycle, then frame -> cmd_cnt 1->0; dir=0, pos_y=230, pos_x=320.
- Wrap: heading right, 31 frames from reset -> pos_x reaches 630 at frame 31; frame 32 -> pos_x=0. Then key left and a frame -> pos_x=630.
- Keys up, left, down, right, up on consecutive cycles, no frame -> cmd_cnt=4, ovf=1. Four frames -> dir sequence 0,2,1,3; cmd_cnt ends 0; ovf stays 1.
- key_flag=4'b0011 and key_flag=4'b0000 -> no push, cmd_cnt unchanged, ovf unchanged. key_flag=4'b0100 coincident with frame on an empty FIFO -> that frame keeps dir; the next frame applies left.
- sys_rst_n low for one cycle while in MOVE -> no upd pulse; pos=(320,240), dir=3, cmd_cnt=0, ovf=0 at that edge.
